// File: rtl/cpu_pkg.sv
// cpu_pkg -- definitions shared by the external-bus blocks of the CPU slice.
//
// Contents:
//   BW_8 / BW_16 / BW_32      bus-width codes. These are the same encoding
//                             the BSC uses in its area-size field.
//   ST_IDLE / ST_ACC / ST_HOLD  external bus target FSM state encoding.
//   lane_be()                 maps an external bus cycle onto 32-bit
//                             backend byte enables.
package cpu_pkg;

  // Area-size / port-width encoding.
  localparam logic [1:0] BW_8  = 2'b01;
  localparam logic [1:0] BW_16 = 2'b10;
  localparam logic [1:0] BW_32 = 2'b11;

  // External bus target FSM states.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // Byte-enable mapping for one external bus cycle.
  //
  // The mapping is big-endian: BE bit 3 is byte 0, which sits on
  // data[31:24]. The narrow-port strobes are used as follows:
  //   - an 8-bit port uses WE_N[0];
  //   - a 16-bit port uses WE_N[1] for the upper (even-address) byte and
  //     WE_N[0] for the lower byte.
  // A read enables every lane the port covers. A write enables only those
  // lanes whose strobe is active.
  function automatic logic [3:0] lane_be(input logic [1:0] bus_w,
                                         input logic [1:0] a_lo,
                                         input logic [3:0] we_n,
                                         input logic       rd);
    logic [3:0] lanes;
    logic [3:0] strobes;
    lanes   = 4'h0;
    strobes = 4'h0;
    case (bus_w)
      BW_8: begin
        lanes   = 4'b0001 << (2'd3 - a_lo);
        strobes = {4{~we_n[0]}};
      end
      BW_16: begin
        lanes   = a_lo[1] ? 4'b0011 : 4'b1100;
        strobes = {2{~we_n[1:0]}};
      end
      BW_32: begin
        lanes   = 4'hF;
        strobes = ~we_n;
      end
      default: begin
        lanes   = 4'h0;
        strobes = 4'h0;
      end
    endcase
    return rd ? lanes : (lanes & strobes);
  endfunction

endpackage

// File: rtl/ext_bus_target.sv
// ext_bus_target -- memory-like target on the CPU external bus.
//
// The block turns external bus cycles on one chip-select area into
// single-word requests on a simple backend port. It also answers
// interrupt vector fetches directly, without going to the backend.
//
// Parameters
//   CS_IDX   external area (0-3) this target serves. This value is
//            informational only; the selected chip select arrives on CS_N.
//   BUS_W    port width, using the area-size encoding
//            (BW_8, BW_16 or BW_32).
//
// Ports
//   CLK, RST               system clock; synchronous active-high reset
//   CE_R, CE_F             rising/falling bus-phase clock enables. Only
//                          CE_F is used.
//   A[26:0]                external address
//   DI[31:0]               write data from the initiator
//   DO[31:0], DOE          read data to the initiator and its drive enable
//   BS_N, CS_N, RD_N,      bus start, chip select, read strobe and vector
//   IVECF_N                fetch (all active-low)
//   WE_N[3:0]              byte write strobes (active-low)
//   WAIT_N                 wait request to the initiator (active-low)
//   VEC[7:0]               vector number returned on a vector fetch
//   MEM_*                  backend request port (see handshake note below)
//   DBG_STATE[1:0]         current FSM state (encoding from cpu_pkg)
//
// Backend handshake: MEM_REQ is a level that rises together with MEM_A,
// MEM_BE, MEM_WE and MEM_DO. All of these stay stable while MEM_REQ is
// high. The first CLK that sees MEM_ACK=1 while a request is outstanding
// completes the transfer; MEM_DI is captured on that same CLK, and
// MEM_REQ drops after it. MEM_ACK seen at any other time is ignored.
//
// Bus sampling, and every update of WAIT_N, DO and DOE, happens only on
// CE_F clocks. The backend side runs on every CLK.
module ext_bus_target
  import cpu_pkg::*;
#(
  parameter int         CS_IDX = 0,
  parameter logic [1:0] BUS_W  = BW_32
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE_R,
  input  logic        CE_F,
  input  logic [26:0] A,
  input  logic [31:0] DI,
  output logic [31:0] DO,
  output logic        DOE,
  input  logic        BS_N,
  input  logic        CS_N,
  input  logic        RD_N,
  input  logic        IVECF_N,
  input  logic [3:0]  WE_N,
  output logic        WAIT_N,
  input  logic [7:0]  VEC,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [24:0] MEM_A,
  output logic [3:0]  MEM_BE,
  output logic [31:0] MEM_DO,
  input  logic [31:0] MEM_DI,
  input  logic        MEM_ACK,
  output logic [1:0]  DBG_STATE
);

  logic [1:0]  state_q;
  logic        ack_seen_q;
  logic        rd_q;        // latched ~RD_N of the access in flight
  logic [1:0]  a_lo_q;      // latched A[1:0], used to place read data
  logic [31:0] cap_q;       // MEM_DI captured on the accepted ACK

  logic [3:0]  start_be;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  // CE_R and CS_IDX play no part in the logic here.
  logic unused_ok;
  assign unused_ok = CE_R ^ (CS_IDX > 3);

  assign DBG_STATE = state_q;
  assign start_be  = lane_be(BUS_W, A[1:0], WE_N, ~RD_N);

  // Narrow ports replicate their write data across the whole word, so
  // every enabled lane carries the right byte. Read data is taken from
  // the lane(s) the access addressed and returned right-justified.
  always_comb begin
    wr_data = DI;
    rd_data = cap_q;
    case (BUS_W)
      BW_8: begin
        wr_data = {4{DI[7:0]}};
        case (a_lo_q)
          2'd0:    rd_data = {24'h0, cap_q[31:24]};
          2'd1:    rd_data = {24'h0, cap_q[23:16]};
          2'd2:    rd_data = {24'h0, cap_q[15:8]};
          default: rd_data = {24'h0, cap_q[7:0]};
        endcase
      end
      BW_16: begin
        wr_data = {2{DI[15:0]}};
        rd_data = {16'h0, (a_lo_q[1] ? cap_q[15:0] : cap_q[31:16])};
      end
      default: begin
        wr_data = DI;
        rd_data = cap_q;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      ack_seen_q <= 1'b0;
      rd_q       <= 1'b0;
      a_lo_q     <= 2'b00;
      cap_q      <= 32'h0;
      WAIT_N     <= 1'b1;
      DO         <= 32'h0;
      DOE        <= 1'b0;
      MEM_REQ    <= 1'b0;
      MEM_WE     <= 1'b0;
      MEM_A      <= 25'h0;
      MEM_BE     <= 4'h0;
      MEM_DO     <= 32'h0;
    end else begin
      // Backend completion runs on any CLK. It is only honoured while a
      // request is actually outstanding.
      if (state_q == ST_ACC && MEM_REQ && MEM_ACK) begin
        MEM_REQ    <= 1'b0;
        ack_seen_q <= 1'b1;
        cap_q      <= MEM_DI;
      end

      if (CE_F) begin
        if (state_q == ST_ACC) begin
          // A new BS_N is ignored here; we are waiting to finish.
          if (ack_seen_q) begin
            WAIT_N  <= 1'b1;
            DO      <= rd_data;
            DOE     <= rd_q;
            state_q <= ST_HOLD;
          end
        end else if (!BS_N && !IVECF_N) begin
          // Vector fetch: answered locally; the chip select is irrelevant.
          DO      <= {24'h0, VEC};
          DOE     <= 1'b1;
          WAIT_N  <= 1'b1;
          state_q <= ST_HOLD;
        end else if (!BS_N && !CS_N) begin
          if (RD_N && start_be == 4'h0) begin
            // A write with no strobe in our lanes has nothing to transfer.
            state_q <= ST_HOLD;
          end else begin
            MEM_REQ    <= 1'b1;
            MEM_WE     <= RD_N;
            MEM_A      <= A[26:2];
            MEM_BE     <= start_be;
            MEM_DO     <= wr_data;
            WAIT_N     <= 1'b0;
            rd_q       <= ~RD_N;
            a_lo_q     <= A[1:0];
            ack_seen_q <= 1'b0;
            state_q    <= ST_ACC;
          end
        end else if (state_q != ST_IDLE && CS_N && IVECF_N) begin
          // End of the bus cycle: release the data bus.
          DOE     <= 1'b0;
          state_q <= ST_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_ext_bus_target.sv
// tb_ext_bus_target -- bench for ext_bus_target.
//
// Three targets (8-, 16- and 32-bit ports) share one external bus and each
// has its own backend responder. A byte-level model of the bus protocol
// predicts the following for every target:
//   - each backend request;
//   - WAIT_N, MEM_REQ and DOE on every CLK;
//   - DO whenever it is driven.
module tb_ext_bus_target;
  import cpu_pkg::*;

  localparam int NI = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ce_r, ce_f;
  logic [26:0] a;
  logic [31:0] di;
  logic        bs_n, cs_n, rd_n, ivecf_n;
  logic [3:0]  we_n;
  logic [7:0]  vec;

  logic [31:0] do_o      [NI];
  logic        doe       [NI];
  logic        wait_n    [NI];
  logic        mem_req   [NI];
  logic        mem_we    [NI];
  logic [24:0] mem_a     [NI];
  logic [3:0]  mem_be    [NI];
  logic [31:0] mem_do    [NI];
  logic [31:0] mem_di    [NI];
  logic        mem_ack   [NI];
  logic [1:0]  dbg_state [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam logic [1:0] BW = (g == 0) ? BW_8 : (g == 1) ? BW_16 : BW_32;
    ext_bus_target #(.CS_IDX(g), .BUS_W(BW)) u_dut (
      .CLK(clk), .RST(rst), .CE_R(ce_r), .CE_F(ce_f),
      .A(a), .DI(di), .DO(do_o[g]), .DOE(doe[g]),
      .BS_N(bs_n), .CS_N(cs_n), .RD_N(rd_n), .IVECF_N(ivecf_n),
      .WE_N(we_n), .WAIT_N(wait_n[g]), .VEC(vec),
      .MEM_REQ(mem_req[g]), .MEM_WE(mem_we[g]), .MEM_A(mem_a[g]),
      .MEM_BE(mem_be[g]), .MEM_DO(mem_do[g]), .MEM_DI(mem_di[g]),
      .MEM_ACK(mem_ack[g]), .DBG_STATE(dbg_state[g])
    );
  end

  // ---------------- scoreboard / model state ----------------
  int vectors     = 0;
  int miscompares = 0;

  // Expected backend requests, one entry per request:
  //   [63:62] target, [61] we, [60:36] word address, [35:32] be, [31:0] data
  logic [63:0] exp_q[$];

  logic        in_acc   [NI];
  logic        acked    [NI];
  logic        holding  [NI];
  logic        req_exp  [NI];
  logic        wait_exp [NI];
  logic        doe_exp  [NI];
  logic        rd_lat   [NI];
  logic [1:0]  alo_lat  [NI];
  logic [31:0] do_exp   [NI];
  logic [31:0] cap_exp  [NI];
  logic        prev_req [NI];
  logic [63:0] last_req [NI];
  int          age      [NI];
  int          req_cnt  [NI];

  int          ack_lat;
  logic        ack_en;
  logic [31:0] rsp_data;

  task automatic chk(input string tag, input int w, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, w, obs, exp);
    end
  endtask

  // ---------------- byte-level reference model ----------------
  function automatic int nbytes(input int w);
    return (w == 0) ? 1 : (w == 1) ? 2 : 4;
  endfunction

  // The port covers an aligned group of nb bytes. Within that group, port
  // offset o carries strobe WE_N[nb-1-o].
  function automatic logic [3:0] m_be(input int w, input logic [1:0] alo,
                                      input logic [3:0] wen, input logic rd);
    int nb = nbytes(w);
    int base = (int'(alo) / nb) * nb;
    logic [3:0] be = 4'h0;
    for (int o = 0; o < nb; o++)
      if (rd || !wen[nb-1-o]) be[3-(base+o)] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input int w, input logic [31:0] d);
    int nb = nbytes(w);
    logic [31:0] r = 32'h0;
    for (int k = 0; k < 4; k++) r[8*(3-k) +: 8] = d[8*(nb-1-(k % nb)) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_rdata(input int w, input logic [1:0] alo, input logic [31:0] mdi);
    int nb = nbytes(w);
    int base = (int'(alo) / nb) * nb;
    logic [31:0] r = 32'h0;
    for (int o = 0; o < nb; o++) r[8*(nb-1-o) +: 8] = mdi[8*(3-(base+o)) +: 8];
    return r;
  endfunction

  function automatic logic any_busy();
    return in_acc[0] | in_acc[1] | in_acc[2];
  endfunction

  // ---------------- driver: one CLK, then model + checks + backend ----------------
  task automatic step(input logic cef);
    logic ack_pre [NI];
    logic [3:0]  be;
    logic [63:0] obs;
    int idx;
    ce_f = cef;
    ce_r = !cef && ($urandom_range(0, 3) == 0);
    for (int w = 0; w < NI; w++) ack_pre[w] = mem_ack[w];
    @(posedge clk);
    #1;
    for (int w = 0; w < NI; w++) begin
      if (rst) begin
        in_acc[w] = 0; acked[w] = 0; holding[w] = 0; req_exp[w] = 0;
        wait_exp[w] = 1; doe_exp[w] = 0; do_exp[w] = 32'h0;
      end else begin
        if (cef && in_acc[w]) begin
          if (acked[w]) begin
            in_acc[w] = 0; holding[w] = 1; wait_exp[w] = 1;
            do_exp[w] = m_rdata(w, alo_lat[w], cap_exp[w]);
            doe_exp[w] = rd_lat[w];
          end
        end else if (cef && !bs_n && !ivecf_n) begin
          do_exp[w] = {24'h0, vec}; doe_exp[w] = 1; wait_exp[w] = 1; holding[w] = 1;
        end else if (cef && !bs_n && !cs_n) begin
          be = m_be(w, a[1:0], we_n, !rd_n);
          if (rd_n && be == 4'h0) begin
            holding[w] = 1;
          end else begin
            exp_q.push_back({2'(w), rd_n, a[26:2], be, m_wdata(w, di)});
            req_exp[w] = 1; wait_exp[w] = 0; in_acc[w] = 1; acked[w] = 0;
            holding[w] = 0; rd_lat[w] = !rd_n; alo_lat[w] = a[1:0];
          end
        end else if (cef && holding[w] && cs_n && ivecf_n) begin
          doe_exp[w] = 0; holding[w] = 0;
        end
        // An ACK counts only when it meets an outstanding request.
        if (ack_pre[w] && in_acc[w] && req_exp[w]) begin
          req_exp[w] = 0; acked[w] = 1; cap_exp[w] = mem_di[w];
        end
      end

      chk("wait_n", w, 64'(wait_n[w]), 64'(wait_exp[w]));
      chk("mem_req", w, 64'(mem_req[w]), 64'(req_exp[w]));
      chk("doe", w, 64'(doe[w]), 64'(doe_exp[w]));
      if (doe_exp[w]) chk("do", w, 64'(do_o[w]), 64'(do_exp[w]));

      if (mem_req[w] && !prev_req[w]) begin
        obs = {2'(w), mem_we[w], mem_a[w], mem_be[w], mem_do[w]};
        last_req[w] = obs;
        req_cnt[w]++;
        idx = -1;
        foreach (exp_q[i]) if (idx < 0 && exp_q[i][63:62] == 2'(w)) idx = i;
        chk("req_expected", w, 64'(idx >= 0), 64'd1);
        if (idx >= 0) begin
          chk("req_fields", w, obs, exp_q[idx]);
          exp_q.delete(idx);
        end
      end
      prev_req[w] = mem_req[w];

      // Backend responder.
      if (mem_ack[w]) begin
        mem_ack[w] = 0;
        age[w] = 0;
      end else if (mem_req[w] && ack_en) begin
        age[w]++;
        if (age[w] >= ack_lat) begin
          mem_ack[w] = 1; mem_di[w] = rsp_data; age[w] = 0;
        end
      end else begin
        age[w] = 0;
      end
    end
  endtask

  // One bus access, started on a CE_F; returns when no target is in ACC.
  task automatic access(input logic [26:0] addr, input logic rdn, input logic [3:0] wen,
                        input logic [31:0] d, input int lat, input logic [31:0] rsp);
    int n;
    a = addr; rd_n = rdn; we_n = wen; di = d;
    bs_n = 0; cs_n = 0; ivecf_n = 1;
    ack_lat = lat; rsp_data = rsp;
    step(1);
    bs_n = 1;
    n = 0;
    while (any_busy() && n < 400) begin
      step((n % 4) == 3);
      n++;
    end
    chk("acc_timeout", 0, 64'(any_busy()), 64'd0);
    chk("req_missing", 0, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic release_bus();
    cs_n = 1; bs_n = 1; ivecf_n = 1;
    step(0); step(0); step(0); step(1);
    for (int w = 0; w < NI; w++) chk("state_idle", w, 64'(dbg_state[w]), 64'(ST_IDLE));
  endtask

  task automatic check_reset_outputs();
    for (int w = 0; w < NI; w++) begin
      chk("rst_wait_n", w, 64'(wait_n[w]), 64'd1);
      chk("rst_doe", w, 64'(doe[w]), 64'd0);
      chk("rst_do", w, 64'(do_o[w]), 64'd0);
      chk("rst_mem_req", w, 64'(mem_req[w]), 64'd0);
      chk("rst_mem_we", w, 64'(mem_we[w]), 64'd0);
      chk("rst_mem_a", w, 64'(mem_a[w]), 64'd0);
      chk("rst_mem_be", w, 64'(mem_be[w]), 64'd0);
      chk("rst_mem_do", w, 64'(mem_do[w]), 64'd0);
      chk("rst_state", w, 64'(dbg_state[w]), 64'(ST_IDLE));
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int c0;
    int cnt [NI];
    logic        r_rd;
    logic [3:0]  r_we;
    rst = 1; ce_r = 0; ce_f = 0; a = '0; di = '0; bs_n = 1; cs_n = 1; rd_n = 1;
    ivecf_n = 1; we_n = 4'hF; vec = '0; ack_en = 1; ack_lat = 3; rsp_data = '0;
    for (int w = 0; w < NI; w++) begin
      mem_ack[w] = 0; mem_di[w] = '0; prev_req[w] = 0; last_req[w] = '0;
      age[w] = 0; req_cnt[w] = 0; in_acc[w] = 0; acked[w] = 0; holding[w] = 0;
      req_exp[w] = 0; wait_exp[w] = 1; doe_exp[w] = 0; rd_lat[w] = 0;
      alo_lat[w] = '0; do_exp[w] = '0; cap_exp[w] = '0;
    end
    repeat (3) step(0);
    rst = 0;
    check_reset_outputs();

    // 32-bit read: ACK three CLKs after MEM_REQ.
    access(27'h0000100, 1'b0, 4'hF, 32'h0, 3, 32'h12345678);
    chk("r32_mem_a", 2, 64'(last_req[2][60:36]), 64'h40);
    chk("r32_mem_be", 2, 64'(last_req[2][35:32]), 64'hF);
    chk("r32_mem_we", 2, 64'(last_req[2][61]), 64'd0);
    chk("r32_do", 2, 64'(do_o[2]), 64'h12345678);
    chk("r32_doe", 2, 64'(doe[2]), 64'd1);
    release_bus();

    // 8-bit write to byte 2.
    access(27'h0000202, 1'b1, 4'b1110, 32'h000000A5, 2, $urandom);
    chk("w8_mem_be", 0, 64'(last_req[0][35:32]), 64'b0010);
    chk("w8_mem_do", 0, 64'(last_req[0][31:0]), 64'hA5A5A5A5);
    chk("w8_mem_we", 0, 64'(last_req[0][61]), 64'd1);
    release_bus();

    // 16-bit longword write: two back-to-back sub-cycles, CS_N held low.
    c0 = req_cnt[1];
    access(27'h0000300, 1'b1, 4'b1100, 32'h0000CAFE, 2, $urandom);
    chk("b2b_be_first", 1, 64'(last_req[1][35:32]), 64'b1100);
    chk("b2b_hold", 1, 64'(dbg_state[1]), 64'(ST_HOLD));
    access(27'h0000302, 1'b1, 4'b1100, 32'h0000BABE, 4, $urandom);
    chk("b2b_be_second", 1, 64'(last_req[1][35:32]), 64'b0011);
    chk("b2b_pulses", 1, 64'(req_cnt[1] - c0), 64'd2);
    release_bus();

    // Empty write sub-cycle.
    for (int w = 0; w < NI; w++) cnt[w] = req_cnt[w];
    access(27'h0000010, 1'b1, 4'hF, $urandom, 2, $urandom);
    for (int i = 0; i < 8; i++) step((i % 4) == 3);
    for (int w = 0; w < NI; w++) begin
      chk("empty_no_req", w, 64'(req_cnt[w] - cnt[w]), 64'd0);
      chk("empty_wait_n", w, 64'(wait_n[w]), 64'd1);
    end
    release_bus();

    // Vector fetch.
    for (int w = 0; w < NI; w++) cnt[w] = req_cnt[w];
    a = 27'h7; vec = 8'h47; bs_n = 0; ivecf_n = 0; cs_n = 1;
    step(1);
    bs_n = 1;
    for (int i = 0; i < 4; i++) step((i % 4) == 3);
    for (int w = 0; w < NI; w++) begin
      chk("vec_do", w, 64'(do_o[w]), 64'h47);
      chk("vec_doe", w, 64'(doe[w]), 64'd1);
      chk("vec_wait_n", w, 64'(wait_n[w]), 64'd1);
      chk("vec_no_req", w, 64'(req_cnt[w] - cnt[w]), 64'd0);
    end
    release_bus();
    for (int w = 0; w < NI; w++) chk("vec_release_doe", w, 64'(doe[w]), 64'd0);

    // Reset in the middle of ACC, followed by a late ACK.
    ack_en = 0;
    a = 27'h0000100; rd_n = 0; we_n = 4'hF; bs_n = 0; cs_n = 0; ivecf_n = 1;
    step(1);
    bs_n = 1;
    step(0); step(0);
    rst = 1; cs_n = 1; rd_n = 1;
    step(0);
    rst = 0;
    check_reset_outputs();
    for (int w = 0; w < NI; w++) begin
      mem_ack[w] = 1; mem_di[w] = 32'hDEADBEEF;
    end
    step(0); step(1);
    for (int w = 0; w < NI; w++) begin
      chk("late_ack_req", w, 64'(mem_req[w]), 64'd0);
      chk("late_ack_state", w, 64'(dbg_state[w]), 64'(ST_IDLE));
    end
    ack_en = 1;
    access(27'h0000104, 1'b0, 4'hF, 32'h0, 1, 32'hCAFEF00D);
    chk("post_rst_do", 2, 64'(do_o[2]), 64'hCAFEF00D);
    chk("post_rst_mem_a", 2, 64'(last_req[2][60:36]), 64'h41);
    release_bus();

    // Random accesses; the bus is sometimes released and sometimes kept.
    for (int n = 0; n < 40; n++) begin
      r_rd = 1'($urandom_range(0, 1));
      r_we = 4'($urandom);
      if (!r_rd || $urandom_range(0, 4) == 0) r_we = 4'hF;
      access(27'($urandom), r_rd, r_we, $urandom, $urandom_range(1, 6), $urandom);
      if ($urandom_range(0, 1) == 1) release_bus();
    end
    release_bus();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ext_bus_target.md
EXT_BUS_TARGET -- requirements
Module: ext_bus_target

Interface
REQ-001 Parameter CS_IDX, default 0: external area (0-3) this target serves; informational, the selected chip select is wired to CS_N.
REQ-002 Parameter BUS_W, default 2'b11: port width using the area-size encoding (01=8, 10=16, 11=32 bit).
REQ-003 CLK  in  1  system clock; single clock domain.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 CE_R / CE_F  in  1 each  rising/falling bus-phase clock enables.
REQ-006 A  in  27  external address.
REQ-007 DI  in  32  write data from the initiator.
REQ-008 DO  out  32  read data to the initiator.
REQ-009 DOE  out  1  DO drive enable.
REQ-010 BS_N, CS_N, RD_N, IVECF_N  in  1 each  bus start, selected chip select, read strobe, vector fetch, all active-low.
REQ-011 WE_N  in  4  byte write strobes, active-low.
REQ-012 WAIT_N  out  1  wait request to the initiator, active-low.
REQ-013 VEC  in  8  vector number returned on vector fetch.
REQ-014 MEM_REQ  out  1, MEM_WE  out  1, MEM_A  out  25 (word address A[26:2]), MEM_BE  out  4, MEM_DO  out  32, MEM_DI  in  32, MEM_ACK  in  1: backend handshake.

Function
REQ-015 All bus sampling and all WAIT_N/DO/DOE updates occur only on CE_F clocks; MEM_ACK is accepted on any CLK.
REQ-016 The FSM has states IDLE, ACC and HOLD.
REQ-017 Access start: CE_F with BS_N=0, CS_N=0 and IVECF_N=1, in IDLE or HOLD.
REQ-018 Lane mapping is big-endian; BE bit 3 is byte 0.
REQ-019 BUS_W=01: byte lane 3-A[1:0] enabled; write data is DI[7:0] replicated; read returns that byte on DO[7:0].
REQ-020 BUS_W=10: lanes {3,2} when A[1]=0, {1,0} when A[1]=1; WE_N[1] is the upper byte; data travels on DI/DO[15:0].
REQ-021 BUS_W=11: BE=~WE_N for writes, 4'hF for reads.
REQ-022 Read: RD_N=0 at start; MEM_WE=0; BE per width.
REQ-023 Write: any active WE_N lane; MEM_WE=1; BE is the enabled lanes ANDed with the active strobes.
REQ-024 Empty access (RD_N=1 and computed BE=0): no backend request; go directly to HOLD; WAIT_N stays 1.
REQ-025 Non-empty start: register MEM_REQ=1, MEM_A, MEM_BE, MEM_WE, MEM_DO; drive WAIT_N=0 at the same CE_F; enter ACC.
REQ-026 ACC: MEM_REQ holds until the first CLK with MEM_ACK=1, then drops the next CLK; ACK_SEEN is set; read data is captured from MEM_DI.
REQ-027 ACC exit: on the first CE_F with ACK_SEEN=1, WAIT_N=1, DO=captured data (lane-placed), DOE=~RD_N-latched, go to HOLD.
REQ-028 HOLD: DO and DOE are held; a new access start (back-to-back sub-cycle, CS_N kept low) is handled as REQ-017; CS_N=1 at CE_F gives DOE=0 and IDLE.
REQ-029 Vector fetch: CE_F with BS_N=0 and IVECF_N=0 (CS_N ignored) gives DO={24'h0,VEC}, DOE=1, WAIT_N=1, HOLD, no backend request; IVECF_N=1 with CS_N=1 releases.
REQ-030 MEM_ACK in IDLE or HOLD is ignored; BS_N=0 while in ACC is ignored.
REQ-031 Zero-wait areas are not supported; areas mapped to this target are programmed with W>=01 (BSC samples WAIT_N on the first TW CE_R).

Reset
REQ-032 RST at any CLK, including mid-ACC, gives IDLE, WAIT_N=1, DOE=0, DO=0, MEM_REQ=0, MEM_WE=0, MEM_BE=0, MEM_A=0, MEM_DO=0, ACK_SEEN=0.
REQ-033 After RST, an ACK still pending from the abandoned request is discarded per REQ-030.

Structure
REQ-034 The state enum and the bus-width encoding constants (shared with the BSC area-size field) live in CPU_PKG.
REQ-035 Lane mapping is one function; there are no sub-modules.

Verification
REQ-036 32-bit read, A=0x0000100, MEM_ACK 3 CLKs after MEM_REQ, MEM_DI=0x12345678 -> MEM_A=0x40, BE=F, WAIT_N low until the ACK CE_F, DO=0x12345678, DOE=1.
REQ-037 8-bit write A[1:0]=2, WE_N=1110, DI=0xA5 -> MEM_BE=0010, MEM_DO=0xA5A5A5A5, MEM_WE=1.
REQ-038 16-bit longword write as 2 back-to-back sub-cycles with CS_N held low -> 2 MEM_REQ pulses with BE 1100 then 0011, no IDLE between.
REQ-039 Empty sub-cycle (WE_N=1111, RD_N=1) -> no MEM_REQ, WAIT_N stays 1.
REQ-040 Vector fetch, VEC=0x47, A=0x7 -> DO=0x00000047, WAIT_N=1, no MEM_REQ.
REQ-041 RST 2 CLKs into ACC, then late MEM_ACK -> all outputs at reset values, ACK ignored, next access normal.
